// File: rtl/sgm_pkg.sv
// Shared constants for the SGM pipeline blocks.
//   LINE_WIDTH : default pixels per line
//   PIX_W      : default pixel / cost word width in bits
package sgm_pkg;
    localparam int LINE_WIDTH = 640;
    localparam int PIX_W      = 8;
endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: simple dual-port RAM addressed by {bank, ptr}.
// One write port and one registered read port. The read register is the
// 1-cycle output latency of the line reverser. It only updates on a read
// enable, so it holds its value while the pipeline is stalled.
//   clk   : clock
//   rst   : synchronous active-high reset (read register only)
//   we    : write enable
//   waddr : write address {bank, ptr}
//   wdata : write data
//   re    : read enable (already qualified by ce)
//   raddr : read address {bank, ptr}
//   rdata : registered read data
module line_bank_ram #(
    parameter int N  = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [N-1:0]  rdata
);
    localparam int DEPTH = 2 ** (AW + 1);

    logic [N-1:0] mem [0:DEPTH-1];

    // Storage is not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/line_reverser.sv
// Streaming line reverser. Pixels arrive in raster order. Each completed
// line is emitted in reverse column order from a ping-pong line store: one
// bank is written while the other is read. Reads run in lockstep with
// writes, with drain advancing the read side at end of frame.
//   clk       : clock
//   rst       : synchronous active-high reset
//   ce        : clock enable, freezes all state and outputs when low
//   in_valid  : in_data carries a pixel
//   in_data   : input pixel
//   drain     : advance the read side without a write
//   out_valid : out_data/out_eol valid
//   out_data  : reversed-order pixel
//   out_eol   : last output pixel of a line (column 0)
module line_reverser
    import sgm_pkg::*;
#(
    parameter int N     = PIX_W,
    parameter int WIDTH = LINE_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    input  logic          drain,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          out_eol
);
    localparam int            AW   = $clog2(WIDTH);
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_bank, rd_bank, rd_active;
    logic          wr_step, rd_step;

    assign wr_step = ce && in_valid;
    assign rd_step = ce && rd_active && (in_valid || drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_ptr    <= '0;
            rd_bank   <= 1'b0;
            rd_active <= 1'b0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
        end else if (ce) begin
            out_valid <= rd_step;
            if (rd_step) begin
                out_eol <= (rd_ptr == '0);
                rd_ptr  <= rd_ptr - 1'b1;
                if (rd_ptr == '0)
                    rd_active <= 1'b0;
            end
            // Completion is assigned last so it overrides the final read of
            // the previous line: the read moves straight to the new bank.
            if (wr_step) begin
                if (wr_ptr == LAST) begin
                    wr_ptr    <= '0;
                    wr_bank   <= ~wr_bank;
                    rd_bank   <= wr_bank;
                    rd_ptr    <= LAST;
                    rd_active <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    line_bank_ram #(.N(N), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_step),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (in_data),
        .re    (rd_step),
        .raddr ({rd_bank, rd_ptr}),
        .rdata (out_data)
    );
endmodule

// File: tb/tb_line_reverser.sv
module tb_line_reverser;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1, ce = 1'b0, in_valid = 1'b0, drain = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_valid, out_eol;
    logic [7:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: completed lines are queued reversed; each read step
    // pops one entry, which appears on the outputs after the clock edge.
    logic [7:0] part[$];
    logic [7:0] pend_d[$];
    bit         pend_e[$];
    logic       m_valid = 1'b0, m_eol = 1'b0;
    logic [7:0] m_data = '0;

    always #5 clk = ~clk;

    line_reverser #(.N(8), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
        .drain(drain), .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol)
    );

    task automatic step(input bit r, input bit c, input bit v, input logic [7:0] d, input bit dr);
        rst = r; ce = c; in_valid = v; in_data = d; drain = dr;
        if (r) begin
            part.delete(); pend_d.delete(); pend_e.delete();
            m_valid = 1'b0; m_data = '0; m_eol = 1'b0;
        end else if (c) begin
            if (pend_d.size() > 0 && (v || dr)) begin
                m_valid = 1'b1;
                m_data  = pend_d.pop_front();
                m_eol   = pend_e.pop_front();
            end else begin
                m_valid = 1'b0;
            end
            if (v) begin
                part.push_back(d);
                if (part.size() == W) begin
                    for (int i = W - 1; i >= 0; i--) begin
                        pend_d.push_back(part[i]);
                        pend_e.push_back(i == 0);
                    end
                    part.delete();
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 8'h00, 0);
        step(1, 1, 1, 8'hAA, 1);
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_eol !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got v=%b d=%h e=%b, want v=0 d=00 e=0", out_valid, out_data, out_eol);
        end
    endtask

    // Two lines; also collects the emitted stream against the literal answer.
    task automatic test_two_lines();
        logic [7:0] got[$];
        logic [7:0] want[4];
        want = '{8'd4, 8'd3, 8'd2, 8'd1};
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 2 * W + 2; i++) begin
            step(0, 1, i < 2 * W, 8'(i + 1), 0);
            if (out_valid) got.push_back(out_data);
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL two_lines cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
        n_vec++;
        if (got.size() != 4 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2] || got[3] !== want[3]) begin
            n_err++;
            $display("FAIL two_lines_seq: got %0d words %p, want 4 3 2 1", got.size(), got);
        end
    endtask

    task automatic test_drain();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < W + 6; i++) begin
            step(0, 1, i < W, 8'(i + 1), i >= W);
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL drain cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        logic [7:0] want[8];
        int         eols;
        want = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
        eols = 0;
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3 * W; i++) begin
            step(0, 1, 1, 8'(i + 1), 0);
            if (out_valid) begin
                got.push_back(out_data);
                if (out_eol) eols++;
            end
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
        n_vec++;
        if (got.size() != 8 || eols != 2 || got[0] !== want[0] || got[3] !== want[3] ||
            got[4] !== want[4] || got[7] !== want[7]) begin
            n_err++;
            $display("FAIL back_to_back_seq: got %0d words %p eols=%0d, want 4 3 2 1 8 7 6 5 eols=2",
                     got.size(), got, eols);
        end
    endtask

    task automatic test_ce_stall();
        int k;
        k = 0;
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 2 * W + 5; i++) begin
            if (i >= W + 1 && i < W + 4) begin
                step(0, 0, 1, 8'hEE, 1);
            end else begin
                step(0, 1, k < 2 * W, 8'(k + 1), 0);
                k++;
            end
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL ce_stall cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
    endtask

    task automatic test_bubbles();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4 * W + 2; i++) begin
            step(0, 1, (i % 2) == 0, 8'(i / 2 + 1), 0);
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL bubbles cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 8'd1, 0);
        step(0, 1, 1, 8'd2, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 2 * W + 1; i++) begin
            step(0, 1, i < 2 * W, 8'(i + 5), 0);
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data} ||
                (out_valid && (out_data == 8'd1 || out_data == 8'd2))) begin
                n_err++;
                $display("FAIL mid_reset cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
    endtask

    task automatic test_random();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0);
            n_vec++;
            if ({out_valid, out_eol, out_data} !== {m_valid, m_eol, m_data}) begin
                n_err++;
                $display("FAIL random cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         i, out_valid, out_eol, out_data, m_valid, m_eol, m_data);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_two_lines();
        test_drain();
        test_back_to_back();
        test_ce_stall();
        test_bubbles();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
